// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master round-robin AR arbiter with one outstanding read and R routing back to the grant
module axi_read_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_BITS-1:0]    M0_ARID,
  input  logic [ADDR_BITS-1:0]  M0_ARADDR,
  input  logic [LEN_BITS-1:0]   M0_ARLEN,
  input  logic [SIZE_BITS-1:0]  M0_ARSIZE,
  input  logic [1:0]            M0_ARBURST,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [ID_BITS-1:0]    M0_RID,
  output logic [DATA_BITS-1:0]  M0_RDATA,
  output logic [1:0]            M0_RRESP,
  output logic                  M0_RLAST,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,
  input  logic [ID_BITS-1:0]    M1_ARID,
  input  logic [ADDR_BITS-1:0]  M1_ARADDR,
  input  logic [LEN_BITS-1:0]   M1_ARLEN,
  input  logic [SIZE_BITS-1:0]  M1_ARSIZE,
  input  logic [1:0]            M1_ARBURST,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [ID_BITS-1:0]    M1_RID,
  output logic [DATA_BITS-1:0]  M1_RDATA,
  output logic [1:0]            M1_RRESP,
  output logic                  M1_RLAST,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,
  output logic [IDS_BITS-1:0]   S_ARID,
  output logic [ADDR_BITS-1:0]  S_ARADDR,
  output logic [LEN_BITS-1:0]   S_ARLEN,
  output logic [SIZE_BITS-1:0]  S_ARSIZE,
  output logic [1:0]            S_ARBURST,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [IDS_BITS-1:0]   S_RID,
  input  logic [DATA_BITS-1:0]  S_RDATA,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RLAST,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  output logic                  burst_err
);
  localparam int TAG_BITS = IDS_BITS - ID_BITS;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic last_grant, grant, win, acc, hs, r0, r1;
  logic [LEN_BITS-1:0] beat_cnt;
  logic [TAG_BITS-1:0] tag;
  // Routing trusts the registered grant, so the tag bits of S_RID are never looked at.
  logic unused_rid_tag;
  assign unused_rid_tag = ^S_RID[IDS_BITS-1:ID_BITS];
  assign win = (M0_ARVALID && M1_ARVALID) ? !last_grant : M1_ARVALID;
  assign tag = TAG_BITS'(win ? 2 : 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    acc = 1'b0;
    hs = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    S_ARVALID = 1'b0;
    S_RREADY = 1'b0;
    case (state)
      IDLE: begin
        acc = M0_ARVALID || M1_ARVALID;
        M0_ARREADY = acc && !win;
        M1_ARREADY = acc && win;
        state_n = acc ? ADDR : IDLE;
      end
      ADDR: begin
        S_ARVALID = 1'b1;
        state_n = S_ARREADY ? DATA : ADDR;
      end
      DATA: begin
        S_RREADY = grant ? M1_RREADY : M0_RREADY;
        hs = S_RVALID && S_RREADY;
        state_n = (hs && S_RLAST) ? IDLE : DATA;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_grant <= 1'b1;
      grant <= 1'b0;
      S_ARID <= '0;
      S_ARADDR <= '0;
      S_ARLEN <= '0;
      S_ARSIZE <= '0;
      S_ARBURST <= '0;
      beat_cnt <= '0;
      burst_err <= 1'b0;
    end else begin
      if (acc) begin
        grant <= win;
        last_grant <= win;
        S_ARID <= {tag, win ? M1_ARID : M0_ARID};
        S_ARADDR <= win ? M1_ARADDR : M0_ARADDR;
        S_ARLEN <= win ? M1_ARLEN : M0_ARLEN;
        S_ARSIZE <= win ? M1_ARSIZE : M0_ARSIZE;
        S_ARBURST <= win ? M1_ARBURST : M0_ARBURST;
        beat_cnt <= '0;
      end
      if (hs) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (S_RLAST != (beat_cnt == S_ARLEN)) burst_err <= 1'b1;
      end
    end
  assign r0 = (state == DATA) && !grant;
  assign r1 = (state == DATA) && grant;
  assign M0_RVALID = r0 && S_RVALID;
  assign M0_RLAST = r0 && S_RLAST;
  assign M0_RID = r0 ? S_RID[ID_BITS-1:0] : '0;
  assign M0_RDATA = r0 ? S_RDATA : '0;
  assign M0_RRESP = r0 ? S_RRESP : '0;
  assign M1_RVALID = r1 && S_RVALID;
  assign M1_RLAST = r1 && S_RLAST;
  assign M1_RID = r1 ? S_RID[ID_BITS-1:0] : '0;
  assign M1_RDATA = r1 ? S_RDATA : '0;
  assign M1_RRESP = r1 ? S_RRESP : '0;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of arbitration, AR slice, R routing and burst error detection
module tb_axi_read_arbiter;
  logic clk = 0, rst = 0;
  logic [3:0] M0_ARID = 0, M1_ARID = 0, M0_RID, M1_RID;
  logic [31:0] M0_ARADDR = 0, M1_ARADDR = 0, M0_RDATA, M1_RDATA, S_ARADDR, S_RDATA = 0;
  logic [3:0] M0_ARLEN = 0, M1_ARLEN = 0, S_ARLEN;
  logic [2:0] M0_ARSIZE = 0, M1_ARSIZE = 0, S_ARSIZE;
  logic [1:0] M0_ARBURST = 0, M1_ARBURST = 0, S_ARBURST, M0_RRESP, M1_RRESP, S_RRESP = 0;
  logic M0_ARVALID = 0, M1_ARVALID = 0, M0_ARREADY, M1_ARREADY;
  logic M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID, M0_RREADY = 0, M1_RREADY = 0;
  logic [7:0] S_ARID, S_RID = 0;
  logic S_ARVALID, S_ARREADY = 0, S_RLAST = 0, S_RVALID = 0, S_RREADY, burst_err;
  int passed = 0, failed = 0, total = 0;
  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .burst_err(burst_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One single-beat read with both masters requesting; checks who wins and where R goes.
  task automatic round(input logic m1_wins, input logic [7:0] id);
    #1;
    chk("arb_ready", {M0_ARREADY, M1_ARREADY}, m1_wins ? 2'b01 : 2'b10);
    tick;
    chk("arb_sarid", S_ARID, id);
    chk("arb_addr_ready", {M0_ARREADY, M1_ARREADY}, 2'b00);
    S_ARREADY = 1;
    tick;
    S_ARREADY = 0; S_RVALID = 1; S_RLAST = 1; S_RID = id; S_RDATA = 32'(id);
    #1;
    chk("arb_route", {M0_RVALID, M1_RVALID}, m1_wins ? 2'b01 : 2'b10);
    tick;
    S_RVALID = 0; S_RLAST = 0;
  endtask
  logic [6:0] pat = 7'b1010110;
  int k;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sarvalid", S_ARVALID, 0);
    chk("rst_arready", {M0_ARREADY, M1_ARREADY}, 0);
    chk("rst_rready", S_RREADY, 0);
    chk("rst_berr", burst_err, 0);
    chk("rst_sarid", S_ARID, 0);
    rst = 1;
    tick;
    // single M0 read, ARLEN=3
    M0_ARID = 4'h5; M0_ARADDR = 32'h1000; M0_ARLEN = 3; M0_ARSIZE = 2; M0_ARBURST = 1;
    M0_ARVALID = 1; M0_RREADY = 1;
    #1;
    chk("t1_arready", {M0_ARREADY, M1_ARREADY}, 2'b10);
    tick;
    M0_ARVALID = 0;
    #1;
    chk("t1_sarvalid", S_ARVALID, 1);
    chk("t1_sarid", S_ARID, 8'h15);
    chk("t1_saraddr", S_ARADDR, 32'h1000);
    chk("t1_sarfields", {S_ARLEN, S_ARSIZE, S_ARBURST}, {4'd3, 3'd2, 2'd1});
    tick;
    chk("t1_sarvalid_wait", S_ARVALID, 1);
    S_ARREADY = 1;
    tick;
    S_ARREADY = 0;
    for (int i = 0; i < 4; i++) begin
      S_RVALID = 1; S_RID = 8'h15; S_RDATA = 32'hA0 + 32'(i); S_RLAST = (i == 3);
      #1;
      chk("t1_beat", {M0_RVALID, M0_RLAST, M0_RID, M0_RDATA}, {1'b1, i == 3, 4'h5, 32'hA0 + 32'(i)});
      chk("t1_m1_quiet", {M1_RVALID, M1_RDATA}, 0);
      tick;
    end
    S_RVALID = 0; S_RLAST = 0;
    #1;
    chk("t1_idle_rready", S_RREADY, 0);
    chk("t1_berr", burst_err, 0);
    // round robin after a fresh reset
    rst = 0;
    tick;
    rst = 1;
    M0_ARID = 4'h1; M0_ARLEN = 0; M1_ARID = 4'h2; M1_ARLEN = 0;
    M0_ARVALID = 1; M1_ARVALID = 1; M1_RREADY = 1;
    round(0, 8'h11);
    round(1, 8'h22);
    round(0, 8'h11);
    // S_ARREADY held low: fields stable, no master readies
    M1_ARID = 4'h7; M1_ARADDR = 32'h2000; M1_ARLEN = 3;
    M0_ARID = 4'h3; M0_ARLEN = 0;
    #1;
    chk("t4_arready", {M0_ARREADY, M1_ARREADY}, 2'b01);
    tick;
    M1_ARVALID = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold", {S_ARVALID, M0_ARREADY, M1_ARREADY, S_ARID, S_ARADDR, S_ARLEN},
          {1'b1, 2'b00, 8'h27, 32'h2000, 4'd3});
      tick;
    end
    S_ARREADY = 1;
    tick;
    S_ARREADY = 0;
    // M1 RREADY toggles; data advances only on handshakes
    k = 0;
    for (int c = 0; c < 7 && k < 4; c++) begin
      M1_RREADY = pat[c]; S_RVALID = 1; S_RID = 8'h27; S_RDATA = 32'hB0 + 32'(k); S_RLAST = (k == 3);
      #1;
      chk("t4_rready", S_RREADY, M1_RREADY);
      chk("t4_rdata", {M1_RVALID, M1_RLAST, M1_RID, M1_RDATA}, {1'b1, k == 3, 4'h7, 32'hB0 + 32'(k)});
      chk("t4_m0_arready", M0_ARREADY, 0);
      tick;
      if (pat[c]) k++;
    end
    S_RVALID = 0; S_RLAST = 0; M1_RREADY = 1;
    #1;
    chk("t4_idle", {M0_ARREADY, burst_err}, 2'b10);
    // decode-error single beat to M0
    tick;
    M0_ARVALID = 0;
    #1;
    chk("t5_sar", {S_ARVALID, S_ARID, S_ARLEN}, {1'b1, 8'h13, 4'd0});
    S_ARREADY = 1;
    tick;
    S_ARREADY = 0; S_RVALID = 1; S_RRESP = 2'b11; S_RLAST = 1; S_RID = 8'h13; S_RDATA = 0;
    #1;
    chk("t5_resp", {M0_RVALID, M0_RRESP, M0_RLAST, M0_RID}, {1'b1, 2'b11, 1'b1, 4'h3});
    tick;
    S_RVALID = 0; S_RLAST = 0; S_RRESP = 0;
    M1_ARVALID = 1;
    #1;
    chk("t5_idle", {M1_ARREADY, burst_err}, 2'b10);
    // early RLAST on third beat of ARLEN=3
    tick;
    M1_ARVALID = 0; S_ARREADY = 1;
    tick;
    S_ARREADY = 0;
    for (int i = 0; i < 3; i++) begin
      S_RVALID = 1; S_RID = 8'h27; S_RLAST = (i == 2);
      #1;
      chk("t6_pre_err", burst_err, 0);
      tick;
    end
    S_RVALID = 0; S_RLAST = 0;
    #1;
    chk("t6_err", burst_err, 1);
    M0_ARVALID = 1;
    #1;
    chk("t6_idle", M0_ARREADY, 1);
    tick;
    M0_ARVALID = 0; S_ARREADY = 1;
    tick;
    S_ARREADY = 0; S_RVALID = 1; S_RLAST = 1; S_RID = 8'h13;
    tick;
    S_RVALID = 0; S_RLAST = 0;
    #1;
    chk("t6_sticky", burst_err, 1);
    // asynchronous reset in the middle of a burst
    M0_ARLEN = 3; M0_ARVALID = 1;
    tick;
    M0_ARVALID = 0; S_ARREADY = 1;
    tick;
    S_ARREADY = 0; S_RVALID = 1; S_RLAST = 0; S_RDATA = 32'h55;
    #1;
    chk("t7_mid", {M0_RVALID, M0_RDATA}, {1'b1, 32'h55});
    rst = 0;
    #1;
    chk("t7_rst", {M0_RVALID, M0_RDATA, S_RREADY, S_ARVALID, burst_err, M0_ARREADY, S_ARID}, 0);
    rst = 1; S_RVALID = 0;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
